led_pwm: RTL and testbench
==========================

LED_PWM -- requirements
Module: led_pwm

Interface
REQ-001 SHALL have parameter PRESCALE, default 390, CLK cycles per PWM count step (minimum 1).
REQ-002 SHALL have parameter FADE_STEP, default 4, PWM periods per brightness step during a fade (minimum 1).
REQ-003 SHALL have port CLK  input  1  sole clock, all logic on rising edge.
REQ-004 SHALL have port RST_N  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port LED_IN  input  1  on/off request from the upstream blinker, asynchronous to CLK.
REQ-006 SHALL have port DUTY  input  8  on-brightness target, 0..255.
REQ-007 SHALL have port LED_OUT  output  1  registered PWM drive to the LED pin.
REQ-008 SHALL have port BUSY  output  1  registered, high while a fade is in progress.

Function
REQ-009 SHALL pass LED_IN through a 2-flop synchronizer; the internal level is lin_s.
REQ-010 SHALL run a prescaler 0..PRESCALE-1 and emit a one-cycle tick when it equals PRESCALE-1, then wrap to 0.
REQ-011 SHALL increment an 8-bit PWM counter on each tick, wrapping 255->0; PWM period = 256*PRESCALE clocks.
REQ-012 SHALL define wrap as tick with PWM counter == 255; all brightness and state updates occur only at wrap.
REQ-013 SHALL compute target = lin_s ? DUTY : 0, sampled at wrap; DUTY changes mid-period are not visible until the next wrap.
REQ-014 SHALL drive LED_OUT registered as (PWM counter < level): level 0 gives constant low, level 255 gives high for 255 of 256 counts.
REQ-015 SHALL be glitch-free: level changes never take effect mid-period.
REQ-016 With fade compiled in, SHALL use FSM states IDLE, UP, DOWN; at reset the state is IDLE.
REQ-017 In IDLE at wrap: level<target -> UP; level>target -> DOWN; equal -> stay.
REQ-018 In UP, every FADE_STEP-th wrap: level+1; entering IDLE when level reaches target.
REQ-019 In DOWN, every FADE_STEP-th wrap: level-1; entering IDLE when level reaches target.
REQ-020 On reversal (target crosses the current level while in UP or DOWN), SHALL switch direction at that wrap without a step; the step counter restarts.
REQ-021 SHALL never step level past target, and never wrap level beyond 0 or 255.
REQ-022 SHALL drive BUSY = (state != IDLE), registered.

Reset
REQ-023 SHALL, while RST_N=0, immediately force LED_OUT=0, BUSY=0, level=0, prescaler=0, PWM counter=0, synchronizer=0, step counter=0, state=IDLE.
REQ-024 SHALL resume counting on the first CLK edge after RST_N deasserts; assertion mid-fade aborts the fade with no residue.

Configuration
REQ-025 SHALL use macro LED_PWM_FADE_EN to compile in the fade logic.
REQ-026 With LED_PWM_FADE_EN defined, SHALL implement REQ-016..REQ-022.
REQ-027 Without LED_PWM_FADE_EN, SHALL set level = target at every wrap, omit the FSM and step counter, and tie BUSY to 0; FADE_STEP is then ignored.

Verification (PRESCALE=1, period 256 clocks)
REQ-028 Reset: RST_N=0 with LED_IN=1, DUTY=200 -> LED_OUT=0, BUSY=0 for the whole reset, including asynchronously mid-cycle.
REQ-029 No fade: DUTY=64, LED_IN 0->1 -> from the first wrap after the 2-cycle sync, LED_OUT high exactly 64 of every 256 clocks.
REQ-030 Fade, FADE_STEP=1, DUTY=4, LED_IN=1 -> high time per period is 1,2,3,4,4; BUSY high from the first wrap until level=4, then 0.
REQ-031 Reversal: as REQ-030, then drop LED_IN when level=2 -> DOWN at the next wrap, then high times 1,0; BUSY falls when level=0.
REQ-032 Boundaries: DUTY=0, LED_IN=1 -> LED_OUT never high, BUSY stays 0; DUTY=255 at level 255 -> high 255 of 256 clocks.
REQ-033 Mid-fade reset: RST_N=0 during UP at level 3 -> LED_OUT=0, BUSY=0 immediately; after release, the ramp restarts from 0.

Source files
------------

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - LED PWM driver with synchronised on/off request and optional brightness fade
// Fade ramping is compiled in with `define LED_PWM_FADE_EN; otherwise brightness snaps to target each period.
module led_pwm #(
  parameter int PRESCALE  = 390,
  parameter int FADE_STEP = 4
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LED_IN,
  input  logic [7:0] DUTY,
  output logic       LED_OUT,
  output logic       BUSY
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

  if (PRESCALE < 1 || FADE_STEP < 1) begin : g_bad_param
    $error("led_pwm: PRESCALE and FADE_STEP must be at least 1");
  end

  logic          lin_m;
  logic          lin_s;
  logic [PW-1:0] pre;
  logic [7:0]    pwm_cnt;
  logic [7:0]    level;
  logic [7:0]    target;
  logic          tick;
  logic          wrap;

  assign tick   = (pre == PRE_MAX);
  assign wrap   = tick && (pwm_cnt == 8'hFF);
  assign target = lin_s ? DUTY : 8'd0;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lin_m <= 1'b0;
      lin_s <= 1'b0;
    end else begin
      lin_m <= LED_IN;
      lin_s <= lin_m;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      pre     <= '0;
      pwm_cnt <= 8'd0;
    end else begin
      pre <= tick ? '0 : pre + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // level only moves at wrap, so the compare never sees a mid-period change
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) LED_OUT <= 1'b0;
    else        LED_OUT <= (pwm_cnt < level);
  end

`ifdef LED_PWM_FADE_EN
  localparam int SW = (FADE_STEP > 1) ? $clog2(FADE_STEP) : 1;
  localparam logic [SW-1:0] STEP_MAX = SW'(FADE_STEP - 1);

  typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

  state_t        state;
  logic [SW-1:0] step_cnt;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state    <= IDLE;
      step_cnt <= '0;
      level    <= 8'd0;
      BUSY     <= 1'b0;
    end else if (wrap) begin
      case (state)
        IDLE: begin
          step_cnt <= '0;
          if (level < target) begin
            state <= UP;
            BUSY  <= 1'b1;
          end else if (level > target) begin
            state <= DOWN;
            BUSY  <= 1'b1;
          end
        end
        UP: begin
          if (target < level) begin
            state    <= DOWN;
            step_cnt <= '0;
          end else if (target == level) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            step_cnt <= '0;
          end else if (step_cnt == STEP_MAX) begin
            level    <= level + 8'd1;
            step_cnt <= '0;
            if (level + 8'd1 == target) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        DOWN: begin
          if (target > level) begin
            state    <= UP;
            step_cnt <= '0;
          end else if (target == level) begin
            state    <= IDLE;
            BUSY     <= 1'b0;
            step_cnt <= '0;
          end else if (step_cnt == STEP_MAX) begin
            level    <= level - 8'd1;
            step_cnt <= '0;
            if (level - 8'd1 == target) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end else begin
            step_cnt <= step_cnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          BUSY     <= 1'b0;
          step_cnt <= '0;
        end
      endcase
    end
  end
`else
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      level <= 8'd0;
      BUSY  <= 1'b0;
    end else begin
      BUSY <= 1'b0;
      if (wrap) level <= target;
    end
  end
`endif

endmodule

// File: tb/tb_led_pwm.sv
// tb/tb_led_pwm.sv - scoreboard bench for led_pwm; follows LED_PWM_FADE_EN like the design
// Expected per-period high time and busy time come from a period-level model of the brightness rules.
module tb_led_pwm;

  localparam int FADE_STEP = 1;
`ifdef LED_PWM_FADE_EN
  localparam int FULL_PERIODS = 257;
`else
  localparam int FULL_PERIODS = 3;
`endif

  typedef struct {
    int high;
    bit busy;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b1;
  logic       LED_IN = 1'b1;
  logic [7:0] DUTY = 8'd200;
  logic       LED_OUT;
  logic       BUSY;

  led_pwm #(.PRESCALE(1), .FADE_STEP(FADE_STEP)) dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .LED_IN (LED_IN),
    .DUTY   (DUTY),
    .LED_OUT(LED_OUT),
    .BUSY   (BUSY)
  );

  always #5 CLK = ~CLK;

  // clock edges since reset release; with PRESCALE=1 a wrap lands on every multiple of 256
  int ec;
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) ec <= 0;
    else        ec <= ec + 1;
  end

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];
  int   m_lvl = 0;
  int   m_dir = 0;
`ifdef LED_PWM_FADE_EN
  int   m_cnt = 0;
`endif

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_lvl = 0;
    m_dir = 0;
`ifdef LED_PWM_FADE_EN
    m_cnt = 0;
`endif
    sb.delete();
    sb.push_back('{0, 1'b0});
  endtask

  task automatic model_wrap();
    int tgt;
    tgt = LED_IN ? int'(DUTY) : 0;
`ifdef LED_PWM_FADE_EN
    if (m_dir == 0) begin
      if (m_lvl < tgt)      m_dir = 1;
      else if (m_lvl > tgt) m_dir = -1;
      m_cnt = 0;
    end else if ((m_dir > 0 && tgt < m_lvl) || (m_dir < 0 && tgt > m_lvl)) begin
      m_dir = -m_dir;
      m_cnt = 0;
    end else if (tgt == m_lvl) begin
      m_dir = 0;
      m_cnt = 0;
    end else begin
      m_cnt++;
      if (m_cnt == FADE_STEP) begin
        m_cnt = 0;
        m_lvl += m_dir;
        if (m_lvl == tgt) m_dir = 0;
      end
    end
`else
    m_lvl = tgt;
`endif
    sb.push_back('{m_lvl, m_dir != 0});
  endtask

  // monitor: integrate LED_OUT and BUSY over each 256-clock window, then score it
  int hi_cnt = 0;
  int busy_cnt = 0;
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!RST_N) begin
        hi_cnt   = 0;
        busy_cnt = 0;
      end else if (ec > 0) begin
        hi_cnt   += int'(LED_OUT);
        busy_cnt += int'(BUSY);
        if (ec % 256 == 0) begin
          check("sb_nonempty", sb.size() > 0, 1);
          if (sb.size() > 0) begin
            e = sb.pop_front();
            check("high_time", hi_cnt, e.high);
            check("busy_time", busy_cnt, e.busy ? 256 : 0);
          end
          hi_cnt   = 0;
          busy_cnt = 0;
        end
      end
    end
  end

  // one PWM period of stimulus: request/duty mid-period, a second duty change before wrap
  task automatic run_period(input bit lin, input logic [7:0] da, input logic [7:0] db);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    while (!done && n < 300) begin
      @(negedge CLK);
      n++;
      case (ec % 256)
        100: begin
          LED_IN = lin;
          DUTY   = da;
        end
        180: DUTY = db;
        0: if (ec != 0) begin
          model_wrap();
          done = 1'b1;
        end
        default: ;
      endcase
    end
    check("period_timeout", done, 1);
  endtask

  task automatic do_reset(input bit at_high);
    int n;
    if (at_high) begin
      n = 0;
      do begin
        @(negedge CLK);
        n++;
      end while (ec % 256 != 1 && n < 300);
      check("pre_reset_led", LED_OUT, m_lvl > 0);
    end
    #2 RST_N = 1'b0;
    LED_IN = 1'b1;
    DUTY   = 8'd200;
    #1;
    check("rst_led_async", LED_OUT, 0);
    check("rst_busy_async", BUSY, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      check("rst_led_hold", LED_OUT, 0);
      check("rst_busy_hold", BUSY, 0);
    end
    model_reset();
    RST_N = 1'b1;
  endtask

  initial begin
    do_reset(1'b0);
    run_period(1'b0, 8'd64, 8'd64);
    repeat (3) run_period(1'b1, 8'd64, 8'd64);

    do_reset(1'b1);
    repeat (7) run_period(1'b1, 8'd4, 8'd4);

    do_reset(1'b1);
    for (int i = 0; i < 8 && m_lvl != 2; i++) run_period(1'b1, 8'd4, 8'd4);
    repeat (5) run_period(1'b0, 8'd4, 8'd4);

    do_reset(1'b1);
    repeat (3) run_period(1'b1, 8'd0, 8'd0);
    repeat (FULL_PERIODS) run_period(1'b1, 8'd255, 8'd255);

    do_reset(1'b1);
    for (int i = 0; i < 8 && m_lvl != 3; i++) run_period(1'b1, 8'd6, 8'd6);
    do_reset(1'b1);
    repeat (4) run_period(1'b1, 8'd6, 8'd6);

    for (int i = 0; i < 20; i++)
      run_period(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom_range(0, 6)));

    @(negedge CLK);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
